// File: rtl/ahb_lite_pkg.sv
// Shared encodings, FSM states and burst helpers for the AHB-Lite memory subordinate.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BurstSingle = 3'b000,
        BurstIncr   = 3'b001,
        BurstWrap4  = 3'b010,
        BurstIncr4  = 3'b011,
        BurstWrap8  = 3'b100,
        BurstIncr8  = 3'b101,
        BurstWrap16 = 3'b110,
        BurstIncr16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        SizeByte   = 3'b000,
        SizeHalf   = 3'b001,
        SizeWord   = 3'b010,
        SizeDword  = 3'b011,
        SizeQword  = 3'b100,
        SizeOword  = 3'b101,
        Size512    = 3'b110,
        Size1024   = 3'b111
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE_ST,
        WAIT_ST,
        DATA_ST,
        ERR1_ST,
        ERR2_ST
    } state_e;

    // Beats in a burst; INCR has no fixed length and reports 0.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            BurstWrap4, BurstIncr4:   burst_beats = 5'd4;
            BurstWrap8, BurstIncr8:   burst_beats = 5'd8;
            BurstWrap16, BurstIncr16: burst_beats = 5'd16;
            BurstIncr:                burst_beats = 5'd0;
            default:                  burst_beats = 5'd1;
        endcase
    endfunction

    function automatic logic burst_is_wrap(input logic [2:0] hburst);
        burst_is_wrap = (hburst == BurstWrap4) || (hburst == BurstWrap8) ||
                        (hburst == BurstWrap16);
    endfunction

endpackage

// File: rtl/ahb_burst_addr_chk.sv
// Tracks the address the next SEQ beat must carry (incrementing or wrapping bursts)
// and flags a SEQ beat that does not match it.
module ahb_burst_addr_chk
    import ahb_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  update,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    output logic                  seq_mismatch
);

    logic [ADDR_WIDTH-1:0] expected;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_expected;

    always_comb begin
        step      = ADDR_WIDTH'(1) << hsize;
        incr      = haddr + step;
        // Low bits spanning one full wrap window; upper bits stay put on wrap.
        wrap_mask = (ADDR_WIDTH'(burst_beats(hburst)) << hsize) - ADDR_WIDTH'(1);
        if (burst_is_wrap(hburst)) begin
            next_expected = (haddr & ~wrap_mask) | (incr & wrap_mask);
        end else begin
            next_expected = incr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= '0;
        end else if (update) begin
            expected <= next_expected;
        end
    end

    assign seq_mismatch = (haddr != expected);

endmodule

// File: rtl/ahb_lite_mem_sub.sv
// Parametrised AHB-Lite memory subordinate with byte lanes, error checks and RAW forwarding.
// Optional wait states are compiled in with the AHB_SUB_WAIT_STATES_EN macro.
module ahb_lite_mem_sub
    import ahb_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64 || DATA_WIDTH == 128)) begin : g_bad_width
        $error("ahb_lite_mem_sub: DATA_WIDTH must be 32, 64 or 128");
    end
    if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ahb_lite_mem_sub: MEM_DEPTH must be a power of two");
    end
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 7) begin : g_bad_waits
        $error("ahb_lite_mem_sub: WAIT_CYCLES must be in 1..7");
    end

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_e                state;
    logic                  ready_out;
    logic                  resp_out;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  dp_write;
    logic [IDX_W-1:0]      dp_idx;
    logic [BYTES-1:0]      dp_mask;

    logic                  sample;
    logic                  active;
    logic                  update;
    logic                  seq_mismatch;
    logic                  size_err;
    logic                  align_err;
    logic                  range_err;
    logic                  seq_err;
    logic                  ap_err;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [IDX_W-1:0]      ap_idx;
    logic [BYTES-1:0]      ap_mask;
    logic [IDX_W-1:0]      rd_idx;
    logic [BYTES-1:0]      rd_mask;
    logic                  wr_en;
    logic                  fwd;
    logic [DATA_WIDTH-1:0] rd_word;

    // Our own HREADYOUT gates sampling so nothing is taken during WAIT_ST or ERR1_ST.
    assign sample = HSEL & HREADY & ready_out;
    assign active = sample & HTRANS[1];

    always_comb begin
        align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
        size_err   = HSIZE > 3'(OFF_W);
        align_err  = |(HADDR & align_mask);
        range_err  = |(HADDR >> (IDX_W + OFF_W));
        seq_err    = (HTRANS == TransSeq) && seq_mismatch;
        ap_err     = size_err | align_err | range_err | seq_err;
        ap_idx     = HADDR[IDX_W+OFF_W-1:OFF_W];
        // For an aligned transfer, lane b is enabled when it shares the size-aligned block.
        for (int b = 0; b < BYTES; b++) begin
            ap_mask[b] = ((OFF_W'(b)) >> HSIZE) == (HADDR[OFF_W-1:0] >> HSIZE);
        end
    end

    assign update = active & ~ap_err;

    ahb_burst_addr_chk #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_burst_addr_chk (
        .clk          (HCLK),
        .rst_n        (HRESETn),
        .update       (update),
        .haddr        (HADDR),
        .hsize        (HSIZE),
        .hburst       (HBURST),
        .seq_mismatch (seq_mismatch)
    );

`ifdef AHB_SUB_WAIT_STATES_EN
    logic [2:0] wait_cnt;

    // After waiting, the read is served from the captured data-phase address.
    assign rd_idx  = (state == WAIT_ST) ? dp_idx  : ap_idx;
    assign rd_mask = (state == WAIT_ST) ? dp_mask : ap_mask;
`else
    assign rd_idx  = ap_idx;
    assign rd_mask = ap_mask;
`endif

    assign wr_en = (state == DATA_ST) & dp_write;
    assign fwd   = wr_en && (dp_idx == rd_idx);

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (rd_mask[b]) begin
                if (fwd && dp_mask[b]) begin
                    rd_word[8*b +: 8] = HWDATA[8*b +: 8];
                end else begin
                    rd_word[8*b +: 8] = mem[rd_idx][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (dp_mask[b]) begin
                    mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE_ST;
            ready_out <= 1'b1;
            resp_out  <= HRESP_OKAY;
            rdata     <= '0;
            dp_write  <= 1'b0;
            dp_idx    <= '0;
            dp_mask   <= '0;
`ifdef AHB_SUB_WAIT_STATES_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
`ifdef AHB_SUB_WAIT_STATES_EN
                WAIT_ST: begin
                    if (wait_cnt == 3'd0) begin
                        state     <= DATA_ST;
                        ready_out <= 1'b1;
                        if (!dp_write) begin
                            rdata <= rd_word;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
`endif
                ERR1_ST: begin
                    state     <= ERR2_ST;
                    ready_out <= 1'b1;
                    resp_out  <= HRESP_ERROR;
                end
                default: begin
                    // IDLE_ST, DATA_ST and ERR2_ST all accept a new address phase.
                    state     <= IDLE_ST;
                    ready_out <= 1'b1;
                    resp_out  <= HRESP_OKAY;
                    if (active) begin
                        if (ap_err) begin
                            state     <= ERR1_ST;
                            ready_out <= 1'b0;
                            resp_out  <= HRESP_ERROR;
                        end else begin
                            dp_write <= HWRITE;
                            dp_idx   <= ap_idx;
                            dp_mask  <= ap_mask;
`ifdef AHB_SUB_WAIT_STATES_EN
                            state     <= WAIT_ST;
                            ready_out <= 1'b0;
                            wait_cnt  <= 3'(WAIT_CYCLES - 1);
`else
                            state <= DATA_ST;
                            if (!HWRITE) begin
                                rdata <= rd_word;
                            end
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = ready_out;
    assign HRESP     = resp_out;

endmodule

// File: tb/tb_ahb_lite_mem_sub.sv
// Self-checking bench for ahb_lite_mem_sub against a byte-array memory model.
module tb_ahb_lite_mem_sub;

    localparam int unsigned DW        = 32;
    localparam int unsigned AW        = 32;
    localparam int unsigned DEPTH     = 256;
    localparam int unsigned WAITS     = 2;
    localparam int unsigned MEM_BYTES = DEPTH * 4;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_WRAP4  = 3'b010;
    localparam logic [2:0] B_INCR4  = 3'b011;

    logic          HCLK    = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL    = 1'b0;
    logic [AW-1:0] HADDR   = '0;
    logic [1:0]    HTRANS  = 2'b00;
    logic          HWRITE  = 1'b0;
    logic [2:0]    HSIZE   = 3'd2;
    logic [2:0]    HBURST  = 3'd0;
    logic [DW-1:0] HWDATA  = '0;
    logic          HREADY;
    logic [DW-1:0] HRDATA;
    logic          HREADYOUT;
    logic          HRESP;

    // Single subordinate on the bus: HREADY is its own HREADYOUT.
    assign HREADY = HREADYOUT;

    ahb_lite_mem_sub #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_DEPTH   (DEPTH),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] hold_rd  = '0;
    logic [31:0] exp_addr = '0;
    bit          pend_valid = 0;
    logic [31:0] pend_rdata = '0;
    logic [31:0] pend_wdata = '0;
    logic        pend_resp  = 1'b0;
    string       pend_tag   = "";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int wrap_beats(input logic [2:0] bu);
        case (bu)
            3'b010:  return 4;
            3'b100:  return 8;
            3'b110:  return 16;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_err(input logic [1:0] tr, input logic [31:0] a, input int sz);
        if (sz > 2) return 1;
        if (a % (32'd1 << sz) != 0) return 1;
        if (a >= MEM_BYTES) return 1;
        if (tr == T_SEQ && a != exp_addr) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input int sz);
        int          off  = int'(a % 4);
        logic [31:0] base = a - 32'(off);
        logic [31:0] r    = '0;
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + (1 << sz)) r[8*b +: 8] = ref_mem[base + 32'(b)];
        end
        return r;
    endfunction

    // Advances the model in issue order, drives one address phase and checks the
    // data phase of the previously issued beat.
    task automatic issue(input string tag, input logic [1:0] tr, input logic wr,
                         input logic [31:0] a, input int sz, input logic [2:0] bu,
                         input logic [31:0] wd);
        logic [31:0] erd   = hold_rd;
        logic        eresp = 1'b0;
        int          n     = 0;
        int          span;
        logic [31:0] base;
        if (tr[1]) begin
            if (m_err(tr, a, sz)) begin
                eresp = 1'b1;
            end else begin
                if (wrap_beats(bu) != 0) begin
                    span     = wrap_beats(bu) << sz;
                    base     = a - (a % 32'(span));
                    exp_addr = base + ((a - base + (32'd1 << sz)) % 32'(span));
                end else begin
                    exp_addr = a + (32'd1 << sz);
                end
                if (wr) begin
                    for (int i = 0; i < (1 << sz); i++)
                        ref_mem[a + 32'(i)] = wd[8*(int'(a % 4) + i) +: 8];
                end else begin
                    erd     = m_read(a, sz);
                    hold_rd = erd;
                end
            end
        end
        HSEL = 1'b1; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = 3'(sz); HBURST = bu;
        HWDATA = pend_wdata;
        @(negedge HCLK);
        while (HREADY !== 1'b1 && n < 40) begin
            n++;
            @(negedge HCLK);
        end
        chk({tag, "/ready"}, 32'(HREADY), 32'd1);
        if (pend_valid) begin
            chk({pend_tag, "/rdata"}, HRDATA, pend_rdata);
            chk({pend_tag, "/resp"}, 32'(HRESP), 32'(pend_resp));
        end
        @(posedge HCLK);
        #1;
        pend_valid = 1;
        pend_tag   = tag;
        pend_rdata = erd;
        pend_resp  = eresp;
        pend_wdata = wd;
    endtask

    task automatic idle(input string tag);
        issue(tag, T_IDLE, 1'b0, 32'h0, 2, B_SINGLE, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sz;
        int          pick;
        logic [31:0] a;

        // Reset values.
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst/hrdata", HRDATA, 32'h0);
        chk("rst/hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst/hresp", 32'(HRESP), 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Fill memory so every later read has a defined expectation.
        for (int w = 0; w < int'(DEPTH); w++) issue("fill", T_NSEQ, 1'b1, 32'(w * 4), 2, B_SINGLE, $urandom);
        idle("fill_end");

        // Word write/read, byte merge and halfword read.
        issue("wr_dead", T_NSEQ, 1'b1, 32'h10, 2, B_SINGLE, 32'hDEADBEEF);
        idle("gap0");
        issue("rd_dead", T_NSEQ, 1'b0, 32'h10, 2, B_SINGLE, 32'h0);
        issue("wr_1122", T_NSEQ, 1'b1, 32'h10, 2, B_SINGLE, 32'h11223344);
        issue("wr_byte", T_NSEQ, 1'b1, 32'h13, 0, B_SINGLE, 32'hAA000000);
        issue("rd_merge", T_NSEQ, 1'b0, 32'h10, 2, B_SINGLE, 32'h0);
        issue("rd_half", T_NSEQ, 1'b0, 32'h12, 1, B_SINGLE, 32'h0);
        idle("gap1");

        // WRAP4 burst, then a mismatching SEQ beat that must error without writing.
        issue("wrap_b0", T_NSEQ, 1'b1, 32'h38, 2, B_WRAP4, 32'hA0A0A0A0);
        issue("wrap_b1", T_SEQ, 1'b1, 32'h3C, 2, B_WRAP4, 32'hA1A1A1A1);
        issue("wrap_b2", T_SEQ, 1'b1, 32'h30, 2, B_WRAP4, 32'hA2A2A2A2);
        issue("wrap_b3", T_SEQ, 1'b1, 32'h34, 2, B_WRAP4, 32'hA3A3A3A3);
        for (int i = 0; i < 4; i++) issue("wrap_rd", T_NSEQ, 1'b0, 32'h30 + 32'(4 * i), 2, B_SINGLE, 32'h0);
        issue("bad_b0", T_NSEQ, 1'b1, 32'h38, 2, B_WRAP4, 32'hB0B0B0B0);
        issue("bad_b1", T_SEQ, 1'b1, 32'h3C, 2, B_WRAP4, 32'hB1B1B1B1);
        issue("bad_seq", T_SEQ, 1'b1, 32'h40, 2, B_WRAP4, 32'hBADBADBA);
        idle("gap2");
        issue("rd_40", T_NSEQ, 1'b0, 32'h40, 2, B_SINGLE, 32'h0);

        // INCR4 with a BUSY beat in the middle.
        issue("busy_b0", T_NSEQ, 1'b1, 32'h80, 2, B_INCR4, 32'hC0C0C0C0);
        issue("busy_gap", T_BUSY, 1'b1, 32'h84, 2, B_INCR4, 32'h0);
        issue("busy_b1", T_SEQ, 1'b1, 32'h84, 2, B_INCR4, 32'hC1C1C1C1);
        issue("busy_b2", T_SEQ, 1'b0, 32'h88, 2, B_INCR4, 32'h0);

        // Unaligned and out-of-range accesses.
        issue("unal_half", T_NSEQ, 1'b1, 32'h01, 1, B_SINGLE, 32'hFFFFFFFF);
        issue("oor_word", T_NSEQ, 1'b1, 32'(MEM_BYTES), 2, B_SINGLE, 32'hFFFFFFFF);
        issue("rd_00", T_NSEQ, 1'b0, 32'h00, 2, B_SINGLE, 32'h0);

        // Read immediately after write to the same word.
        issue("fwd_wr", T_NSEQ, 1'b1, 32'h20, 2, B_SINGLE, 32'h00000055);
        issue("fwd_rd", T_NSEQ, 1'b0, 32'h20, 2, B_SINGLE, 32'h0);
        issue("fwd_wr2", T_NSEQ, 1'b1, 32'h21, 0, B_SINGLE, 32'h00007700);
        issue("fwd_rd2", T_NSEQ, 1'b0, 32'h20, 1, B_SINGLE, 32'h0);
        idle("gap3");

        // Randomized back-to-back single transfers, including error cases.
        for (int i = 0; i < 300; i++) begin
            pick = int'($urandom_range(0, 99));
            sz   = int'($urandom_range(0, 3));
            a    = $urandom_range(0, MEM_BYTES - 1) & ~((32'd1 << sz) - 32'd1);
            if (pick < 8) begin
                idle("rnd_idle");
            end else begin
                if (pick < 14 && sz > 0) a = a + 32'd1;
                if (pick >= 94) a = a + MEM_BYTES;
                issue("rnd", T_NSEQ, 1'($urandom_range(0, 1)), a, sz,
                      (pick % 2 == 0) ? B_SINGLE : B_INCR, $urandom);
            end
        end
        issue("wr_4c", T_NSEQ, 1'b1, 32'h4C, 2, B_SINGLE, 32'hCAFEF00D);
        idle("gap4");
        pend_valid = 0;

        // Read latency: zero-wait by default, WAITS low cycles when wait states are built in.
        HTRANS = T_NSEQ; HWRITE = 1'b0; HADDR = 32'h4C; HSIZE = 3'd2; HBURST = B_SINGLE;
        @(posedge HCLK);
        #1;
        HTRANS = T_IDLE;
`ifdef AHB_SUB_WAIT_STATES_EN
        for (int k = 0; k < int'(WAITS); k++) begin
            chk("lat/wait_ready", 32'(HREADYOUT), 32'd0);
            @(posedge HCLK);
            #1;
        end
`endif
        chk("lat/ready", 32'(HREADYOUT), 32'd1);
        chk("lat/rdata", HRDATA, 32'hCAFEF00D);
        chk("lat/resp", 32'(HRESP), 32'd0);
        @(posedge HCLK);
        #1;

        // Reset during a write's data phase drops the write and clears outputs at once.
        HTRANS = T_NSEQ; HWRITE = 1'b1; HADDR = 32'h44;
        @(posedge HCLK);
        #1;
        HTRANS = T_IDLE; HWDATA = 32'h12345678;
        chk("rstw/hold", HRDATA, 32'hCAFEF00D);
        HRESETn = 1'b0;
        #1;
        chk("rstw/ready", 32'(HREADYOUT), 32'd1);
        chk("rstw/resp", 32'(HRESP), 32'd0);
        chk("rstw/rdata", HRDATA, 32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        hold_rd = '0; exp_addr = '0; pend_valid = 0; pend_wdata = '0;
        issue("rd_44", T_NSEQ, 1'b0, 32'h44, 2, B_SINGLE, 32'h0);
        idle("gap5");
        pend_valid = 0;

        // Two-cycle ERROR timing, then reset in ERR1.
        HTRANS = T_NSEQ; HWRITE = 1'b0; HADDR = 32'h01; HSIZE = 3'd1;
        @(posedge HCLK);
        #1;
        HTRANS = T_IDLE;
        chk("err1/ready", 32'(HREADYOUT), 32'd0);
        chk("err1/resp", 32'(HRESP), 32'd1);
        HRESETn = 1'b0;
        #1;
        chk("rste/ready", 32'(HREADYOUT), 32'd1);
        chk("rste/resp", 32'(HRESP), 32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        hold_rd = '0; exp_addr = '0; pend_wdata = '0;
        issue("post_rst_rd", T_NSEQ, 1'b0, 32'h4C, 2, B_SINGLE, 32'h0);
        idle("end");
        idle("end2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_lite_mem_sub.md
# ahb_lite_mem_sub

Parametrised AHB-Lite memory subordinate. It is the next-generation replacement for the fixed 32-bit subordinate and sits behind the AHB-Lite decoder/multiplexor, one instance per address region. Beyond the previous block it adds:
- byte-lane writes for any legal HSIZE up to DATA_WIDTH;
- alignment and range checking;
- burst address-sequence checking, including wrap;
- read-after-write forwarding;
- the spec-compliant two-cycle ERROR response.

## Interface
Parameters:
- DATA_WIDTH, 32: bus width; legal values 32, 64, 128.
- ADDR_WIDTH, 32: HADDR width.
- MEM_DEPTH, 256: storage depth in DATA_WIDTH words; power of two.
- WAIT_CYCLES, 1: wait states per active transfer; used only when AHB_SUB_WAIT_STATES_EN is defined; range 1..7.

Ports:
- HCLK  in  1  clock; rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  subordinate select.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 bytes.
- HBURST  in  3  SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16.
- HWDATA  in  DATA_WIDTH  write data (data phase).
- HREADY  in  1  bus-level ready; address phase is sampled only when high.
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  0 = extend data phase.
- HRESP  out  1  0 OKAY, 1 ERROR.

## Operation
- **Reset values:** HRDATA = 0, HREADYOUT = 1, HRESP = 0, FSM = IDLE_ST, expected-address register = 0. Memory contents are not reset.
- **Address-phase capture:** when HSEL & HREADY & HTRANS[1], capture HADDR, HWRITE, HSIZE, HBURST and HTRANS. When HSEL & HREADY & HTRANS ∈ {IDLE, BUSY}, the next data phase is a zero-wait OKAY with no side effects.
- **Address decode:**
  - BYTES = DATA_WIDTH/8.
  - Word index = HADDR[log2(MEM_DEPTH)+log2(BYTES)-1 : log2(BYTES)].
  - Lane mask = ((1<<(1<<HSIZE))-1) << HADDR[log2(BYTES)-1:0].
- **Error conditions,** evaluated in the address phase; any one yields an ERROR and suppresses the memory access:
  - (a) HSIZE > log2(BYTES);
  - (b) HADDR not aligned to 1<<HSIZE;
  - (c) HADDR ≥ MEM_DEPTH*BYTES;
  - (d) SEQ beat whose HADDR ≠ expected address.
- **Expected address:**
  - On every accepted NONSEQ/SEQ: expected = HADDR + (1<<HSIZE).
  - For WRAPn, bits [log2(n)+HSIZE-1:0] wrap modulo n*(1<<HSIZE) and upper bits are held.
  - A BUSY beat leaves expected unchanged.
  - A NONSEQ beat reloads expected.
- **Write:** enabled HWDATA lanes are committed at the rising edge that ends the data phase (HREADYOUT = 1). Disabled lanes are unchanged.
- **Read:** HRDATA is loaded from memory at the edge that ends the address phase. Lanes outside the mask read as 0.
- **Read-after-write forwarding:** if the write being committed on that same edge targets the same word, the enabled lanes come from HWDATA.
- **FSM states:** IDLE_ST, WAIT_ST, DATA_ST, ERR1_ST, ERR2_ST.
  - IDLE_ST → DATA_ST: valid transfer with no waits.
  - IDLE_ST → WAIT_ST: valid transfer with waits.
  - IDLE_ST → ERR1_ST: error detected.
  - WAIT_ST → DATA_ST: after WAIT_CYCLES cycles.
  - ERR1_ST → ERR2_ST: always, after one cycle.
  - DATA_ST and ERR2_ST: return to IDLE_ST, or start the next transfer from the newly sampled address phase.
- **HRDATA hold:** HRDATA holds its value outside read data phases.

## Timing
- Zero-wait read: address phase in cycle N, HRDATA valid in cycle N+1 with HREADYOUT = 1.
- Zero-wait write: memory updated at the end of cycle N+1.
- With waits: HREADYOUT = 0 for WAIT_CYCLES cycles, then 1. Memory and HRDATA update only on the final cycle.
- ERROR response:
  - ERR1_ST: HREADYOUT = 0, HRESP = 1.
  - ERR2_ST: HREADYOUT = 1, HRESP = 1.
  - The manager may drive IDLE during ERR1_ST. The address sampled during ERR2_ST is honoured.
- Back-to-back SEQ beats sustain one transfer per cycle without waits.
- HRESETn asserted mid-transfer forces the reset values immediately. A pending write is dropped.

## Configuration
- **AHB_SUB_WAIT_STATES_EN**
  - Defined: every NONSEQ/SEQ transfer gets WAIT_CYCLES wait states. WAIT_ST is compiled in.
  - Undefined: WAIT_ST and its counter are absent. All OKAY transfers are zero-wait; ERROR stays two cycles.

## Structure
- **Package ahb_lite_pkg** holds:
  - HTRANS, HBURST and HSIZE encodings as typedef enums;
  - HRESP_OKAY and HRESP_ERROR;
  - the FSM state enum;
  - the function returning the beat count for a given HBURST.
- **Sub-module ahb_burst_addr_chk:** registers the expected address, performs the wrap/increment arithmetic and outputs seq_mismatch.

## Test plan
- Word write 0xDEADBEEF to 0x10, then read 0x10 → HRDATA = 0xDEADBEEF, HRESP = 0.
- Byte write 0xAA to 0x13 over an existing 0x11223344 → read back 0xAA223344. Halfword read at 0x12 → lanes [31:16] = 0xAA22.
- WRAP4 word burst from 0x38 (beats 0x38, 0x3C, 0x30, 0x34) → all OKAY. A SEQ beat at 0x40 instead of 0x30 → ERR1 then ERR2, no write.
- Unaligned halfword at 0x01, and address MEM_DEPTH*BYTES → two-cycle ERROR each. Memory unchanged.
- Write 0x55 to 0x20 followed immediately by a read of 0x20 → read returns 0x55 (forwarding).
- With AHB_SUB_WAIT_STATES_EN and WAIT_CYCLES = 2: read → HREADYOUT 0, 0, 1. Assert HRESETn low during a wait → HREADYOUT = 1, HRESP = 0, HRDATA = 0 immediately.
